// File: rtl/video_pkg.sv
// video_pkg -- shared video timing definitions.
//
// Purpose: default raster timing constants, the 10-bit count type and
// small helpers used by the timing generator and the character-map stage.
// Ports: none (package).
package video_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned FRAME_W   = 8;
  localparam int unsigned PARAM_MAX = 1023;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Default 512x256 raster, 2 clks per pixel.
  localparam int unsigned H_TOTAL_DEF  = 640;
  localparam int unsigned H_ACTIVE_DEF = 512;
  localparam int unsigned HS_START_DEF = 544;
  localparam int unsigned HS_END_DEF   = 592;
  localparam int unsigned V_TOTAL_DEF  = 262;
  localparam int unsigned V_ACTIVE_DEF = 256;
  localparam int unsigned VS_START_DEF = 258;
  localparam int unsigned VS_END_DEF   = 261;
  localparam int unsigned CE_DIV_DEF   = 2;

  // Half-open window test [lo, hi), unsigned 10-bit.
  function automatic logic in_window(input cnt_t value, input cnt_t lo, input cnt_t hi);
    return (value >= lo) && (value < hi);
  endfunction

  // Ordering rule for one axis: active < sync start < sync end <= total <= 1023.
  function automatic bit timing_ok(input int unsigned active, input int unsigned start,
                                   input int unsigned stop, input int unsigned total);
    return (active < start) && (start < stop) && (stop <= total) && (total <= PARAM_MAX);
  endfunction

endpackage

// File: rtl/ce_gen.sv
// ce_gen -- pixel clock-enable divider.
//
// Purpose: produces a registered one-clk strobe every CE_DIV clks. The first
// strobe appears CE_DIV clks after reset deasserts; with CE_DIV=1 the strobe
// is constantly high outside reset.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset (divider and strobe cleared)
//   ce    out pixel-enable strobe
module ce_gen #(
  parameter int unsigned CE_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic ce
);

  if ((CE_DIV < 1) || (CE_DIV > 16)) begin : g_bad_div
    $error("ce_gen: CE_DIV must be in 1..16");
  end

  localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

  logic [3:0] div_q;
  logic [3:0] div_d;
  logic       ce_q;
  logic       ce_d;

  // Next divider phase; the strobe is raised when the phase wraps.
  always_comb begin
    if (div_q == DIV_LAST) begin
      div_d = 4'd0;
      ce_d  = 1'b1;
    end else begin
      div_d = div_q + 4'd1;
      ce_d  = 1'b0;
    end
  end

  // Divider phase and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 4'd0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/video_timing.sv
// video_timing -- raster timing generator.
//
// Purpose: horizontal/vertical pixel counters, sync, blanking, a
// vertical-blank start pulse and a frame counter. All decoded outputs are
// registered from the next-state counter values so they line up with the
// hcnt/vcnt they describe.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   ce_pix    out one-clk pixel enable every CE_DIV clks
//   hcnt      out horizontal pixel counter (feeds the character map directly)
//   vcnt      out vertical line counter (feeds the character map directly)
//   hsync     out high for hcnt in [HS_START, HS_END)
//   vsync     out high for vcnt in [VS_START, VS_END)
//   hblank    out high for hcnt >= H_ACTIVE
//   vblank    out high for vcnt >= V_ACTIVE
//   vbl_start out one-clk pulse when vcnt becomes V_ACTIVE with hcnt 0
//   frame     out frame counter, modulo 256
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned HS_START = HS_START_DEF,
  parameter int unsigned HS_END   = HS_END_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned VS_START = VS_START_DEF,
  parameter int unsigned VS_END   = VS_END_DEF,
  parameter int unsigned CE_DIV   = CE_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       ce_pix,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       vbl_start,
  output logic [7:0] frame
);

  if (!timing_ok(H_ACTIVE, HS_START, HS_END, H_TOTAL)) begin : g_bad_h
    $error("video_timing: need H_ACTIVE < HS_START < HS_END <= H_TOTAL <= 1023");
  end
  if (!timing_ok(V_ACTIVE, VS_START, VS_END, V_TOTAL)) begin : g_bad_v
    $error("video_timing: need V_ACTIVE < VS_START < VS_END <= V_TOTAL <= 1023");
  end

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACTIVE_C = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACTIVE_C = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START_C = cnt_t'(HS_START);
  localparam cnt_t HS_END_C   = cnt_t'(HS_END);
  localparam cnt_t VS_START_C = cnt_t'(VS_START);
  localparam cnt_t VS_END_C   = cnt_t'(VS_END);

  logic   ce_s;
  logic   h_wrap_s;
  logic   v_wrap_s;

  cnt_t   hcnt_q,      hcnt_d;
  cnt_t   vcnt_q,      vcnt_d;
  frame_t frame_q,     frame_d;
  logic   hsync_q,     hsync_d;
  logic   vsync_q,     vsync_d;
  logic   hblank_q,    hblank_d;
  logic   vblank_q,    vblank_d;
  logic   vbl_start_q, vbl_start_d;

  ce_gen #(
    .CE_DIV(CE_DIV)
  ) u_ce_gen (
    .clk  (clk),
    .reset(reset),
    .ce   (ce_s)
  );

  // Next counter values and the decode of those next values, so the
  // registered sync/blank flags carry zero skew against hcnt/vcnt.
  always_comb begin
    h_wrap_s = (hcnt_q == H_LAST);
    v_wrap_s = (vcnt_q == V_LAST);
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    frame_d  = frame_q;
    if (ce_s) begin
      if (h_wrap_s) begin
        hcnt_d = 10'd0;
        if (v_wrap_s) begin
          vcnt_d  = 10'd0;
          frame_d = frame_q + 8'd1;
        end else begin
          vcnt_d  = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end else begin
      hcnt_d = hcnt_q;
    end
    hsync_d     = in_window(hcnt_d, HS_START_C, HS_END_C);
    vsync_d     = in_window(vcnt_d, VS_START_C, VS_END_C);
    hblank_d    = (hcnt_d >= H_ACTIVE_C);
    vblank_d    = (vcnt_d >= V_ACTIVE_C);
    // Only a line wrap can land on hcnt 0, so this fires once per frame.
    vbl_start_d = ce_s && h_wrap_s && (vcnt_d == V_ACTIVE_C);
  end

  // Counter, frame and decoded flag registers; reset overrides every increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q      <= 10'd0;
      vcnt_q      <= 10'd0;
      frame_q     <= 8'd0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      vbl_start_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_q     <= frame_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      vbl_start_q <= vbl_start_d;
    end
  end

  assign ce_pix    = ce_s;
  assign hcnt      = hcnt_q;
  assign vcnt      = vcnt_q;
  assign frame     = frame_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign hblank    = hblank_q;
  assign vblank    = vblank_q;
  assign vbl_start = vbl_start_q;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing -- self-checking bench for video_timing.
//
// Three instances: A uses the default raster, B a reduced raster with
// CE_DIV=1 large enough to reach hcnt=300/vcnt=100, C a tiny raster with
// CE_DIV=1 for frame-counter wrap. Expected outputs come from a closed-form
// model: the number of pixels elapsed since reset release is derived from the
// clk count, and every output follows from it arithmetically.
module tb_video_timing;

  localparam int B_DIV = 1, B_HT = 302, B_HA = 280, B_HSS = 288, B_HSE = 296;
  localparam int B_VT = 101, B_VA = 96, B_VSS = 98, B_VSE = 100;
  localparam int C_DIV = 1, C_HT = 8, C_HA = 4, C_HSS = 5, C_HSE = 7;
  localparam int C_VT = 4, C_VA = 2, C_VSS = 3, C_VSE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic ce_a, hs_a, vs_a, hb_a, vb_a, vbl_a;
  logic ce_b, hs_b, vs_b, hb_b, vb_b, vbl_b;
  logic ce_c, hs_c, vs_c, hb_c, vb_c, vbl_c;
  logic [9:0] hcnt_a, vcnt_a, hcnt_b, vcnt_b, hcnt_c, vcnt_c;
  logic [7:0] frame_a, frame_b, frame_c;
  logic [33:0] obs_a, obs_b, obs_c;

  int n_cmp = 0;
  int n_fail = 0;
  int t_a = 0, t_b = 0, t_c = 0;

  video_timing dut_a (
    .clk(clk), .reset(rst_a), .ce_pix(ce_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hsync(hs_a), .vsync(vs_a), .hblank(hb_a), .vblank(vb_a),
    .vbl_start(vbl_a), .frame(frame_a)
  );

  video_timing #(
    .H_TOTAL(B_HT), .H_ACTIVE(B_HA), .HS_START(B_HSS), .HS_END(B_HSE),
    .V_TOTAL(B_VT), .V_ACTIVE(B_VA), .VS_START(B_VSS), .VS_END(B_VSE), .CE_DIV(B_DIV)
  ) dut_b (
    .clk(clk), .reset(rst_b), .ce_pix(ce_b), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .hsync(hs_b), .vsync(vs_b), .hblank(hb_b), .vblank(vb_b),
    .vbl_start(vbl_b), .frame(frame_b)
  );

  video_timing #(
    .H_TOTAL(C_HT), .H_ACTIVE(C_HA), .HS_START(C_HSS), .HS_END(C_HSE),
    .V_TOTAL(C_VT), .V_ACTIVE(C_VA), .VS_START(C_VSS), .VS_END(C_VSE), .CE_DIV(C_DIV)
  ) dut_c (
    .clk(clk), .reset(rst_c), .ce_pix(ce_c), .hcnt(hcnt_c), .vcnt(vcnt_c),
    .hsync(hs_c), .vsync(vs_c), .hblank(hb_c), .vblank(vb_c),
    .vbl_start(vbl_c), .frame(frame_c)
  );

  assign obs_a = {ce_a, hcnt_a, vcnt_a, hs_a, vs_a, hb_a, vb_a, vbl_a, frame_a};
  assign obs_b = {ce_b, hcnt_b, vcnt_b, hs_b, vs_b, hb_b, vb_b, vbl_b, frame_b};
  assign obs_c = {ce_c, hcnt_c, vcnt_c, hs_c, vs_c, hb_c, vb_c, vbl_c, frame_c};

  // Reference: t = clks since reset release (0 while in reset). A strobe is
  // visible on clks t = D, 2D, ...; pixels counted n = (t-1)/D.
  function automatic logic [33:0] ref_out(input int t, input int d, input int ht,
      input int ha, input int hss, input int hse, input int vt, input int va,
      input int vss, input int vse);
    int n, h, v, f;
    logic ce, adv, hs, vs, hb, vb, vbl;
    if (t <= 0) return 34'd0;
    n   = (t - 1) / d;
    h   = n % ht;
    v   = (n / ht) % vt;
    f   = (n / (ht * vt)) % 256;
    ce  = ((t % d) == 0);
    adv = (n > 0) && (((t - 1) % d) == 0);
    hs  = (h >= hss) && (h < hse);
    vs  = (v >= vss) && (v < vse);
    hb  = (h >= ha);
    vb  = (v >= va);
    vbl = adv && (h == 0) && (v == va);
    return {ce, 10'(h), 10'(v), hs, vs, hb, vb, vbl, 8'(f)};
  endfunction

  function automatic logic [33:0] ref_a(input int t);
    return ref_out(t, 2, 640, 512, 544, 592, 262, 256, 258, 261);
  endfunction
  function automatic logic [33:0] ref_b(input int t);
    return ref_out(t, B_DIV, B_HT, B_HA, B_HSS, B_HSE, B_VT, B_VA, B_VSS, B_VSE);
  endfunction
  function automatic logic [33:0] ref_c(input int t);
    return ref_out(t, C_DIV, C_HT, C_HA, C_HSS, C_HSE, C_VT, C_VA, C_VSS, C_VSE);
  endfunction

  // Advance one clk; outputs are examined at the following falling edge.
  task automatic tick();
    @(posedge clk);
    t_a = rst_a ? 0 : t_a + 1;
    t_b = rst_b ? 0 : t_b + 1;
    t_c = rst_c ? 0 : t_c + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (4) tick();
    n_cmp++; if (obs_a !== 34'd0) begin n_fail++; $display("FAIL reset_a got %h want %h", obs_a, 34'd0); end
    n_cmp++; if (obs_b !== 34'd0) begin n_fail++; $display("FAIL reset_b got %h want %h", obs_b, 34'd0); end
    n_cmp++; if (obs_c !== 34'd0) begin n_fail++; $display("FAIL reset_c got %h want %h", obs_c, 34'd0); end
  endtask

  task automatic test_ce_start();
    logic [33:0] e;
    rst_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (ce_a !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL ce_start clk %0d ce got %b want %b", k, ce_a, (k % 2) == 0);
      end
      if (k == 2) begin
        n_cmp++; if (hcnt_a !== 10'd0) begin n_fail++; $display("FAIL ce_start hcnt@2 got %0d want 0", hcnt_a); end
      end
      if (k == 3) begin
        n_cmp++; if (hcnt_a !== 10'd1) begin n_fail++; $display("FAIL ce_start hcnt@3 got %0d want 1", hcnt_a); end
      end
      e = ref_a(t_a);
      n_cmp++; if (obs_a !== e) begin n_fail++; $display("FAIL ce_start_model clk %0d got %h want %h", k, obs_a, e); end
    end
  endtask

  task automatic test_line();
    logic hb_at [640];
    logic hs_at [640];
    logic [33:0] e;
    logic [9:0] ph, pv;
    int wraps = 0;
    for (int k = 0; k < 1300; k++) begin
      ph = hcnt_a; pv = vcnt_a;
      tick();
      e = ref_a(t_a);
      n_cmp++;
      if (obs_a !== e) begin
        n_fail++; if (n_fail < 40) $display("FAIL line_model t %0d got %h want %h", t_a, obs_a, e);
      end
      if (vcnt_a == 10'd0) begin hb_at[hcnt_a] = hb_a; hs_at[hcnt_a] = hs_a; end
      if (ph == 10'd639 && hcnt_a == 10'd0) begin
        wraps++;
        n_cmp++;
        if (pv !== 10'd0 || vcnt_a !== 10'd1) begin
          n_fail++; $display("FAIL line_wrap vcnt got %0d->%0d want 0->1", pv, vcnt_a);
        end
      end
    end
    n_cmp++; if (wraps !== 1) begin n_fail++; $display("FAIL line_wrap_count got %0d want 1", wraps); end
    for (int h = 0; h < 640; h++) begin
      n_cmp++;
      if (hb_at[h] !== (h >= 512)) begin n_fail++; $display("FAIL hblank h %0d got %b want %b", h, hb_at[h], h >= 512); end
      n_cmp++;
      if (hs_at[h] !== (h >= 544 && h < 592)) begin
        n_fail++; $display("FAIL hsync h %0d got %b want %b", h, hs_at[h], h >= 544 && h < 592);
      end
    end
  endtask

  task automatic test_random_reset();
    logic [33:0] e;
    int run, hold;
    for (int it = 0; it < 4; it++) begin
      run  = int'($urandom_range(50, 1500));
      hold = int'($urandom_range(1, 3));
      rst_a = 1'b0;
      for (int k = 0; k < run + hold; k++) begin
        if (k == run) rst_a = 1'b1;
        tick();
        e = ref_a(t_a);
        n_cmp++;
        if (obs_a !== e) begin
          n_fail++; if (n_fail < 40) $display("FAIL rand_reset it %0d t %0d got %h want %h", it, t_a, obs_a, e);
        end
      end
    end
    rst_a = 1'b0;
  endtask

  task automatic test_frame();
    logic [33:0] e;
    logic vs_line [B_VT];
    logic [7:0] pf;
    int vbl_n = 0, finc = 0;
    rst_b = 1'b0;
    for (int k = 0; k < B_HT * B_VT + 20; k++) begin
      pf = frame_b;
      tick();
      e = ref_b(t_b);
      n_cmp++;
      if (obs_b !== e) begin
        n_fail++; if (n_fail < 40) $display("FAIL frame_model t %0d got %h want %h", t_b, obs_b, e);
      end
      vs_line[vcnt_b] = vs_b;
      if (vbl_b) begin
        vbl_n++;
        n_cmp++;
        if (hcnt_b !== 10'd0 || vcnt_b !== 10'(B_VA)) begin
          n_fail++; $display("FAIL vbl_pos got %0d/%0d want 0/%0d", hcnt_b, vcnt_b, B_VA);
        end
      end
      if (frame_b != pf) begin
        finc++;
        n_cmp++;
        if (hcnt_b !== 10'd0 || vcnt_b !== 10'd0 || frame_b !== 8'd1) begin
          n_fail++; $display("FAIL frame_inc got h %0d v %0d f %0d want 0 0 1", hcnt_b, vcnt_b, frame_b);
        end
      end
    end
    n_cmp++; if (vbl_n !== 1) begin n_fail++; $display("FAIL vbl_count got %0d want 1", vbl_n); end
    n_cmp++; if (finc !== 1) begin n_fail++; $display("FAIL frame_inc_count got %0d want 1", finc); end
    for (int v = 0; v < B_VT; v++) begin
      n_cmp++;
      if (vs_line[v] !== (v >= B_VSS && v < B_VSE)) begin
        n_fail++; $display("FAIL vsync line %0d got %b want %b", v, vs_line[v], v >= B_VSS && v < B_VSE);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [33:0] e;
    bit found = 1'b0;
    for (int k = 0; k < 31000 && !found; k++) begin
      tick();
      e = ref_b(t_b);
      n_cmp++;
      if (obs_b !== e) begin
        n_fail++; if (n_fail < 40) $display("FAIL mid_model t %0d got %h want %h", t_b, obs_b, e);
      end
      found = (hcnt_b == 10'd300) && (vcnt_b == 10'd100);
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL mid_reach timeout got no hit want h300 v100"); end
    rst_b = 1'b1;
    tick();
    n_cmp++; if (obs_b !== 34'd0) begin n_fail++; $display("FAIL mid_reset got %h want %h", obs_b, 34'd0); end
    rst_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (ce_b !== 1'b1 || hcnt_b !== 10'(k - 1) || vcnt_b !== 10'd0 || frame_b !== 8'd0) begin
        n_fail++; $display("FAIL mid_restart clk %0d got ce %b h %0d v %0d want 1 %0d 0", k, ce_b, hcnt_b, vcnt_b, k - 1);
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [33:0] e;
    logic [7:0] pf;
    int wraps = 0, gaps = 0;
    rst_c = 1'b0;
    for (int k = 0; k < 257 * C_HT * C_VT + 8; k++) begin
      pf = frame_c;
      tick();
      e = ref_c(t_c);
      n_cmp++;
      if (obs_c !== e) begin
        n_fail++; if (n_fail < 40) $display("FAIL wrap_model t %0d got %h want %h", t_c, obs_c, e);
      end
      if (ce_c !== 1'b1) gaps++;
      if (pf == 8'd255 && frame_c == 8'd0) wraps++;
    end
    n_cmp++; if (wraps !== 1) begin n_fail++; $display("FAIL frame_wrap got %0d want 1", wraps); end
    n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL ce_gaps got %0d want 0", gaps); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    test_reset();
    test_ce_start();
    test_line();
    test_random_reset();
    test_frame();
    test_mid_reset();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 640, pixels per line including blanking.
REQ-002 SHALL have parameter H_ACTIVE, default 512, visible pixels per line.
REQ-003 SHALL have parameters HS_START / HS_END, defaults 544 / 592, hsync asserted for hcnt in [HS_START, HS_END).
REQ-004 SHALL have parameter V_TOTAL, default 262, lines per frame.
REQ-005 SHALL have parameter V_ACTIVE, default 256, visible lines.
REQ-006 SHALL have parameters VS_START / VS_END, defaults 258 / 261, vsync asserted for vcnt in [VS_START, VS_END).
REQ-007 SHALL have parameter CE_DIV, default 2, clk cycles per pixel; range 1..16.
REQ-008 SHALL have port clk, input, 1, the single system clock.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port ce_pix, output, 1, one-clk pixel-enable strobe every CE_DIV clks.
REQ-011 SHALL have port hcnt, output, 10, horizontal pixel counter.
REQ-012 SHALL have port vcnt, output, 10, vertical line counter.
REQ-013 SHALL have ports hsync / vsync, output, 1 each, active-high sync.
REQ-014 SHALL have ports hblank / vblank, output, 1 each, high outside the active region.
REQ-015 SHALL have port vbl_start, output, 1, one-clk pulse at the start of vertical blanking.
REQ-016 SHALL have port frame, output, 8, frame counter.

Function
REQ-017 ce_pix SHALL be high for exactly one clk in every CE_DIV clks; with CE_DIV=1 it SHALL be constantly high outside reset.
REQ-018 hcnt SHALL advance only on clks where ce_pix is high; it SHALL wrap from H_TOTAL-1 to 0.
REQ-019 vcnt SHALL increment on the same clk that hcnt wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-020 hsync, vsync, hblank and vblank SHALL be registered and SHALL be valid on the same clk as the hcnt/vcnt value they describe, i.e. zero skew.
REQ-021 hblank SHALL be high for hcnt >= H_ACTIVE; vblank SHALL be high for vcnt >= V_ACTIVE.
REQ-022 vbl_start SHALL pulse for exactly one clk, on the clk where vcnt becomes V_ACTIVE and hcnt becomes 0.
REQ-023 frame SHALL increment by one, modulo 256, on the clk where both hcnt and vcnt wrap to 0.
REQ-024 All comparisons SHALL be unsigned 10-bit; parameter values SHALL be at most 1023, and elaboration SHALL fail if ACTIVE < START < END <= TOTAL does not hold.

Reset
REQ-025 While reset is high: hcnt=0, vcnt=0, frame=0, ce_pix=0, hsync=0, vsync=0, hblank=0, vblank=0, vbl_start=0, and the CE divider=0.
REQ-026 On the first clk after reset deasserts, counting SHALL restart at the origin: the first ce_pix SHALL occur CE_DIV clks later.
REQ-027 Reset asserted mid-line or mid-frame SHALL take priority over every increment on that clk.

Structure
REQ-028 Default timing constants and the 10-bit count type SHALL live in a shared package, video_pkg, which is reused by the character-map stage.
REQ-029 The CE divider SHALL be a separate sub-module, ce_gen (parameter CE_DIV, ports clk/reset/ce).
REQ-030 hcnt/vcnt SHALL feed the character-map stage directly, with no intermediate registers.

Verification
REQ-031 Release reset with defaults -> ce_pix first high at clk 2; hcnt=1 after the first ce_pix; thereafter ce_pix every 2 clks.
REQ-032 Run 640 pixels -> hcnt wraps 639->0 and vcnt goes 0->1 on the same clk; hblank high exactly for hcnt 512..639; hsync high exactly for hcnt 544..591.
REQ-033 Run a full frame (262x640x2 clks) -> vbl_start high exactly once, at vcnt=256/hcnt=0; vsync high for lines 258..260; frame 0->1 at vcnt=0/hcnt=0.
REQ-034 Run 256 frames with CE_DIV=1 -> frame wraps 255->0; no ce_pix gaps.
REQ-035 Assert reset at hcnt=300, vcnt=100 for one clk -> all outputs 0 next clk; the counters restart and reproduce the REQ-031 sequence.
REQ-036 Set H_ACTIVE=600 with HS_START=544 -> elaboration error.
